// File: rtl/k12a_lcd_ctrl_if.sv
// k12a_lcd_ctrl_if
//   Groups the CPU-side request handshake, status flags and the HD44780-style
//   LCD pin signals of the k12a LCD port sequencer.
//   slave  : the sequencer (k12a_lcd_ctrl)
//   master : whatever drives requests and the LCD pin readback (I/O decode
//            plus pad ring, or a testbench)
//   Signals:
//     req_valid/req_ready/req_rs/req_data  request handshake (one byte each)
//     busy, timeout_err                     status
//     lcd_rs/lcd_rw/lcd_en                  LCD control pins
//     lcd_data_out/lcd_data_oe/lcd_data_in  LCD data bus (bit 7 of in = BF)
interface k12a_lcd_ctrl_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_rs;
    logic [7:0] req_data;
    logic       busy;
    logic       timeout_err;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;
    logic [7:0] lcd_data_out;
    logic       lcd_data_oe;
    logic [7:0] lcd_data_in;

    modport slave (
        input  req_valid, req_rs, req_data, lcd_data_in,
        output req_ready, busy, timeout_err, lcd_rs, lcd_rw, lcd_en,
               lcd_data_out, lcd_data_oe
    );

    modport master (
        output req_valid, req_rs, req_data, lcd_data_in,
        input  req_ready, busy, timeout_err, lcd_rs, lcd_rw, lcd_en,
               lcd_data_out, lcd_data_oe
    );
endinterface

// File: rtl/k12a_lcd_ctrl.sv
// k12a_lcd_ctrl
//   Bus-cycle sequencer for the k12a character-LCD port. Accepts one
//   command/data byte per valid/ready handshake, performs the timed write
//   cycle, then repeatedly reads the busy flag until it clears (or the poll
//   limit is reached) before accepting the next byte.
//   Ports:
//     cpu_clock  system clock, rising edge
//     reset      synchronous, active-high
//     bus        k12a_lcd_ctrl_if.slave (request handshake, status, LCD pins)
//   All LCD pins and status outputs come straight from flops.
module k12a_lcd_ctrl #(
    parameter int unsigned SETUP_CYCLES   = 1,
    parameter int unsigned EN_HIGH_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES    = 1,
    parameter int unsigned POLL_LIMIT     = 255
) (
    input logic             cpu_clock,
    input logic             reset,
    k12a_lcd_ctrl_if.slave  bus
);

    localparam int unsigned MaxSE    = (SETUP_CYCLES > EN_HIGH_CYCLES) ? SETUP_CYCLES
                                                                       : EN_HIGH_CYCLES;
    localparam int unsigned MaxPhase = (MaxSE > HOLD_CYCLES) ? MaxSE : HOLD_CYCLES;
    localparam int unsigned CntW     = $clog2(MaxPhase + 1);
    localparam int unsigned PollW    = $clog2(POLL_LIMIT + 1);

    // Counter reload values: a phase of N cycles counts N-1 down to 0.
    localparam logic [CntW-1:0]  SetupLd  = CntW'(SETUP_CYCLES - 1);
    localparam logic [CntW-1:0]  EnLd     = CntW'(EN_HIGH_CYCLES - 1);
    localparam logic [CntW-1:0]  HoldLd   = CntW'(HOLD_CYCLES - 1);
    localparam logic [PollW-1:0] PollLast = PollW'(POLL_LIMIT - 1);

    typedef enum logic [2:0] {
        StIdle, StWSetup, StWEn, StWHold, StPSetup, StPEn, StPHold
    } state_e;

    state_e            r_state, w_state_next;
    logic [CntW-1:0]   r_cnt, w_cnt_next;
    logic [PollW-1:0]  r_poll, w_poll_next;
    logic              r_bf, w_bf_next;
    logic              r_rs_lat, w_rs_lat_next;
    logic              r_timeout, w_timeout_next;
    logic [7:0]        r_data;
    logic              r_ready, r_busy, r_lcd_rs, r_lcd_rw, r_lcd_en, r_lcd_oe;
    logic              w_accept, w_phase_done;
    logic              w_en_next, w_oe_next;
    logic              w_unused;

    // Only the busy flag is read back; the address counter bits are ignored.
    assign w_unused = ^bus.lcd_data_in[6:0];

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_poll_next    = r_poll;
        w_bf_next      = r_bf;
        w_rs_lat_next  = r_rs_lat;
        w_timeout_next = r_timeout;
        w_accept       = 1'b0;
        w_phase_done   = (r_cnt == '0);

        if (r_state != StIdle && !w_phase_done) begin
            w_cnt_next = r_cnt - 1'b1;
        end

        unique case (r_state)
            StIdle: begin
                if (bus.req_valid && r_ready) begin
                    w_accept       = 1'b1;
                    w_rs_lat_next  = bus.req_rs;
                    w_poll_next    = '0;
                    w_timeout_next = 1'b0;
                    w_state_next   = StWSetup;
                    w_cnt_next     = SetupLd;
                end
            end
            StWSetup: if (w_phase_done) begin
                w_state_next = StWEn;
                w_cnt_next   = EnLd;
            end
            StWEn: if (w_phase_done) begin
                w_state_next = StWHold;
                w_cnt_next   = HoldLd;
            end
            StWHold: if (w_phase_done) begin
                w_state_next = StPSetup;
                w_cnt_next   = SetupLd;
            end
            StPSetup: if (w_phase_done) begin
                w_state_next = StPEn;
                w_cnt_next   = EnLd;
            end
            StPEn: if (w_phase_done) begin
                // BF is captured on the edge that ends the last en-high cycle.
                w_bf_next    = bus.lcd_data_in[7];
                w_state_next = StPHold;
                w_cnt_next   = HoldLd;
            end
            StPHold: if (w_phase_done) begin
                if (!r_bf) begin
                    w_state_next = StIdle;
                end else if (r_poll != PollLast) begin
                    w_poll_next  = r_poll + 1'b1;
                    w_state_next = StPSetup;
                    w_cnt_next   = SetupLd;
                end else begin
                    w_timeout_next = 1'b1;
                    w_state_next   = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase

        // Pin values are decoded from the next state so the flops present
        // them in the same cycle the FSM enters that state.
        w_en_next = (w_state_next == StWEn) || (w_state_next == StPEn);
        w_oe_next = (w_state_next == StWSetup) || (w_state_next == StWEn) ||
                    (w_state_next == StWHold);
    end

    always_ff @(posedge cpu_clock) begin
        if (reset) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_poll    <= '0;
            r_bf      <= 1'b0;
            r_rs_lat  <= 1'b0;
            r_timeout <= 1'b0;
            r_data    <= 8'h00;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_lcd_rs  <= 1'b0;
            r_lcd_rw  <= 1'b1;
            r_lcd_en  <= 1'b0;
            r_lcd_oe  <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_poll    <= w_poll_next;
            r_bf      <= w_bf_next;
            r_rs_lat  <= w_rs_lat_next;
            r_timeout <= w_timeout_next;
            if (w_accept) begin
                r_data <= bus.req_data;
            end
            r_ready   <= (w_state_next == StIdle);
            r_busy    <= (w_state_next != StIdle);
            r_lcd_rs  <= w_oe_next & w_rs_lat_next;
            r_lcd_rw  <= ~w_oe_next;
            r_lcd_en  <= w_en_next;
            r_lcd_oe  <= w_oe_next;
        end
    end

    assign bus.req_ready    = r_ready;
    assign bus.busy         = r_busy;
    assign bus.timeout_err  = r_timeout;
    assign bus.lcd_rs       = r_lcd_rs;
    assign bus.lcd_rw       = r_lcd_rw;
    assign bus.lcd_en       = r_lcd_en;
    assign bus.lcd_data_out = r_data;
    assign bus.lcd_data_oe  = r_lcd_oe;

endmodule

// File: doc/k12a_lcd_ctrl.md
Name: k12a_lcd_ctrl

Overview:
Bus-cycle sequencer for the k12a character-LCD port (HD44780-style: lcd_rs, lcd_rw, lcd_en, 8-bit lcd_data).
- CPU-side I/O logic hands it one command/data byte per valid/ready handshake.
- Block generates write timing, then polls the LCD busy flag until clear before accepting the next byte.
- Removes software bit-banging of lcd_en and busy polling; sits between the k12a I/O decode and the lcd_* pins.

Parameters:
SETUP_CYCLES, 1, cycles rs/rw/data are stable with lcd_en low before each enable pulse (>=1)
EN_HIGH_CYCLES, 4, cycles lcd_en is held high per pulse (>=1)
HOLD_CYCLES, 1, cycles rs/rw/data are held after lcd_en falls (>=1)
POLL_LIMIT, 255, maximum busy-flag reads per request before timeout (>=1)

Ports:
cpu_clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  block idle, request accepted when req_valid && req_ready
req_rs  input  1  0 = command, 1 = data
req_data  input  8  byte to write
busy  output  1  high whenever not in IDLE
timeout_err  output  1  sticky: last request's busy polling hit POLL_LIMIT
lcd_rs  output  1  LCD register select
lcd_rw  output  1  LCD read/write (1 = read)
lcd_en  output  1  LCD enable strobe
lcd_data_out  output  8  byte driven to LCD
lcd_data_oe  output  1  1 = drive lcd_data_out onto the pins
lcd_data_in  input  8  LCD pin readback; bit 7 = busy flag

Behaviour:
- Clock/reset: one clock, cpu_clock; reset is synchronous and active-high.
- Reset and IDLE outputs: req_ready=1, busy=0, timeout_err=0 (reset only), lcd_rs=0, lcd_rw=1, lcd_en=0, lcd_data_oe=0, lcd_data_out=8'h00 (reset only; otherwise holds last byte).
- All lcd_* outputs are registered; no combinational path from req_* to pins.
- Reset asserted mid-operation: next edge enters IDLE with reset values; lcd_en drops on that edge; no pending request survives.
- States: IDLE, W_SETUP, W_EN, W_HOLD, P_SETUP, P_EN, P_HOLD. One down-counter, reloaded on each state entry, sets phase duration.
- IDLE: on accept, latch req_rs/req_data, clear timeout_err and poll count, go to W_SETUP. req_valid without req_ready is ignored; requester must hold it.
- W_SETUP (SETUP_CYCLES): lcd_rs=latched rs, lcd_rw=0, lcd_data_oe=1, lcd_en=0.
- W_EN (EN_HIGH_CYCLES): as W_SETUP, lcd_en=1.
- W_HOLD (HOLD_CYCLES): lcd_en=0, rs/rw/data/oe unchanged. Then go to P_SETUP.
- P_SETUP (SETUP_CYCLES): lcd_rs=0, lcd_rw=1, lcd_data_oe=0, lcd_en=0.
- P_EN (EN_HIGH_CYCLES): lcd_en=1; lcd_data_in[7] is sampled at the edge ending the last en-high cycle.
- P_HOLD (HOLD_CYCLES): lcd_en=0, then decide:
  - sampled BF=0: go to IDLE.
  - BF=1 and poll count+1 < POLL_LIMIT: increment count, go to P_SETUP.
  - BF=1 and count+1 == POLL_LIMIT: set timeout_err, go to IDLE.
- Latency with BF clear on first poll: req_ready is low for 2*(S+E+H) cycles after the accept edge; defaults = 12 cycles. Each extra poll adds S+E+H = 6 cycles.
- Counter widths: $clog2(max(S,E,H)+1) for the phase counter, $clog2(POLL_LIMIT+1) for the poll counter; no wrap is possible.
- lcd_data_oe and lcd_rw=0 are never both inactive-contradictory: oe=1 only in W_* states.

Test Plan:
- Reset: hold reset 3 cycles mid-W_EN -> next edge lcd_en=0, lcd_rw=1, oe=0, req_ready=1, lcd_data_out=8'h00.
- Single data write: req_rs=1, req_data=8'h41, lcd_data_in=8'h00 -> lcd_en high exactly 4 cycles with rw=0, rs=1, data 8'h41, oe=1; then one read pulse rs=0, rw=1, oe=0; req_ready returns 12 cycles after accept.
- Busy polling: BF=1 for first 2 polls, then lcd_data_in=8'h00 -> 3 read pulses total, ready after 24 cycles, timeout_err=0.
- Timeout: POLL_LIMIT=3, BF stuck 1 -> exactly 3 read pulses, timeout_err=1, IDLE; next accepted request clears timeout_err.
- Back-to-back: req_valid held high with command 8'h01 then 8'h80 -> second byte accepted only on first IDLE cycle; no lcd_en pulses overlap; req_valid during busy never changes the latched byte.
- Parameter sweep: SETUP=2, EN=1, HOLD=3 -> phase lengths 2/1/3 on both write and poll, latency 12 cycles.
